// File: rtl/montacargas_control.sv
// Freight-elevator sequencer: SCAN call scheduling, door dwell, idle auto-return to floor 1.
// Optional travel watchdog (FALLA state) enabled by defining MONTACARGAS_WATCHDOG_EN.
module montacargas_control #(
  parameter int N_PISOS      = 4,
  parameter int IDLE_TICKS   = 9000,
  parameter int PUERTA_TICKS = 450,
  parameter int VIAJE_TICKS  = 1500
) (
  input  logic                       clockInt_150Hz,
  input  logic                       reset,
  input  logic [N_PISOS-1:0]         llamadaPiso,
  input  logic [N_PISOS-1:0]         sensorPiso,
  output logic                       motorSubir,
  output logic                       motorBajar,
  output logic                       puertaAbrir,
  output logic [$clog2(N_PISOS)-1:0] pisoActual,
  output logic [N_PISOS-1:0]         pendientes,
  output logic [2:0]                 estado
);

  localparam int PW   = $clog2(N_PISOS);
  localparam int MAXT = (IDLE_TICKS > PUERTA_TICKS)
                        ? ((IDLE_TICKS > VIAJE_TICKS) ? IDLE_TICKS : VIAJE_TICKS)
                        : ((PUERTA_TICKS > VIAJE_TICKS) ? PUERTA_TICKS : VIAJE_TICKS);
  localparam int CW   = $clog2(MAXT);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    SUBIENDO = 3'd1,
    BAJANDO  = 3'd2,
    PUERTA   = 3'd3,
    FALLA    = 3'd4
  } estado_e;

  estado_e           estado_q, estado_d;
  logic              dir_up_q, dir_up_d;
  logic [PW-1:0]     piso_q, piso_d;
  logic [N_PISOS-1:0] pend_q, pend_d;
  logic [CW-1:0]     idle_q, idle_d;
  logic [CW-1:0]     dwell_q, dwell_d;
`ifdef MONTACARGAS_WATCHDOG_EN
  logic [CW-1:0]     viaje_q, viaje_d;
`endif

  logic               sensor_ok, above, below;
  logic [PW-1:0]      sensor_idx;
  logic [N_PISOS-1:0] llam;

  always_comb begin
    sensor_ok  = (sensorPiso != '0) && ((sensorPiso & (sensorPiso - 1'b1)) == '0);
    sensor_idx = '0;
    above      = 1'b0;
    below      = 1'b0;
    for (int unsigned k = 0; k < N_PISOS; k++) begin
      if (sensorPiso[k]) sensor_idx = PW'(k);
      if (pend_q[k] && (PW'(k) > piso_q)) above = 1'b1;
      if (pend_q[k] && (PW'(k) < piso_q)) below = 1'b1;
    end
    piso_d = sensor_ok ? sensor_idx : piso_q;
  end

  always_comb begin
    estado_d = estado_q;
    dir_up_d = dir_up_q;
    idle_d   = '0;
    dwell_d  = '0;
    llam     = llamadaPiso;
    // A call for the floor whose door is open only extends the dwell.
    if (estado_q == PUERTA) llam[piso_q] = 1'b0;
    pend_d   = pend_q | llam;

    unique case (estado_q)
      REPOSO: begin
        if (pend_q[piso_q] && sensorPiso[piso_q]) begin
          estado_d       = PUERTA;
          pend_d[piso_q] = 1'b0;
        end else if (above && below) begin
          estado_d = dir_up_q ? SUBIENDO : BAJANDO;
        end else if (above) begin
          estado_d = SUBIENDO;
        end else if (below) begin
          estado_d = BAJANDO;
        end
        if (pend_q == '0 && piso_q != '0) begin
          if (idle_q == CW'(IDLE_TICKS - 1)) pend_d[0] = 1'b1;
          else                               idle_d    = idle_q + CW'(1);
        end
      end
      SUBIENDO: begin
        dir_up_d = 1'b1;
        if (sensor_ok && pend_q[sensor_idx]) begin
          estado_d           = PUERTA;
          pend_d[sensor_idx] = 1'b0;
        end else if (sensorPiso[N_PISOS-1]) begin
          estado_d = REPOSO;
        end
      end
      BAJANDO: begin
        dir_up_d = 1'b0;
        if (sensor_ok && pend_q[sensor_idx]) begin
          estado_d           = PUERTA;
          pend_d[sensor_idx] = 1'b0;
        end else if (sensorPiso[0]) begin
          estado_d = REPOSO;
        end
      end
      PUERTA: begin
        if (llamadaPiso[piso_q])                     dwell_d  = '0;
        else if (dwell_q == CW'(PUERTA_TICKS - 1))   estado_d = REPOSO;
        else                                         dwell_d  = dwell_q + CW'(1);
      end
      default: begin
        pend_d = pend_q;
      end
    endcase

`ifdef MONTACARGAS_WATCHDOG_EN
    viaje_d = '0;
    if (estado_q == SUBIENDO || estado_q == BAJANDO) begin
      if (piso_d != piso_q) begin
        viaje_d = '0;
      end else if (viaje_q == CW'(VIAJE_TICKS - 1)) begin
        estado_d = FALLA;
        pend_d   = pend_q;
      end else begin
        viaje_d = viaje_q + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clockInt_150Hz) begin
    if (reset) begin
      estado_q <= REPOSO;
      dir_up_q <= 1'b1;
      piso_q   <= '0;
      pend_q   <= '0;
      idle_q   <= '0;
      dwell_q  <= '0;
`ifdef MONTACARGAS_WATCHDOG_EN
      viaje_q  <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      dir_up_q <= dir_up_d;
      piso_q   <= piso_d;
      pend_q   <= pend_d;
      idle_q   <= idle_d;
      dwell_q  <= dwell_d;
`ifdef MONTACARGAS_WATCHDOG_EN
      viaje_q  <= viaje_d;
`endif
    end
  end

  assign motorSubir  = (estado_q == SUBIENDO);
  assign motorBajar  = (estado_q == BAJANDO);
  assign puertaAbrir = (estado_q == PUERTA);
  assign pisoActual  = piso_q;
  assign pendientes  = pend_q;
  assign estado      = estado_q;

endmodule

// File: tb/tb_montacargas_control.sv
// Bench for montacargas_control: a simple car plant moves between floors on the motor
// outputs; expected door-open floors are queued when calls are placed and popped on each door cycle.
module tb_montacargas_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] llamadaPiso;
  logic [3:0] sensorPiso;
  logic       motorSubir, motorBajar, puertaAbrir;
  logic [1:0] pisoActual;
  logic [3:0] pendientes;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int pos = 0;
  logic plant_en = 1'b1;

  always #5 clk = ~clk;

  montacargas_control #(
    .N_PISOS(4), .IDLE_TICKS(9000), .PUERTA_TICKS(450), .VIAJE_TICKS(1500)
  ) dut (
    .clockInt_150Hz(clk), .reset(reset), .llamadaPiso(llamadaPiso), .sensorPiso(sensorPiso),
    .motorSubir(motorSubir), .motorBajar(motorBajar), .puertaAbrir(puertaAbrir),
    .pisoActual(pisoActual), .pendientes(pendientes), .estado(estado)
  );

  // Car plant: floor k sits at position 10*k; sensors read zero between floors.
  always @(posedge clk) begin
    #2;
    if (plant_en) begin
      if (motorSubir && pos < 30)      pos = pos + 1;
      else if (motorBajar && pos > 0)  pos = pos - 1;
      sensorPiso = (pos % 10 == 0) ? 4'(1 << (pos / 10)) : 4'b0000;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_call(input logic [3:0] m);
    llamadaPiso = m;
    step(1);
    llamadaPiso = '0;
  endtask

  // Wait for the next door cycle, compare its floor with the scoreboard and measure its length.
  task automatic wait_door(input int restart_at, input int exp_len);
    int n;
    int f;
    int len;
    n = 0;
    while (!puertaAbrir && n < 3000) begin
      step(1);
      n++;
    end
    if (!puertaAbrir) begin
      check("door_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("door_unexpected", 1, 0);
      return;
    end
    f = exp_q.pop_front();
    check("door_floor", 32'(pisoActual), 32'(f));
    check("door_pend_clr", 32'(pendientes[f]), 0);
    check("door_motors", {motorSubir, motorBajar}, 0);
    len = 0;
    while (puertaAbrir && len < 2000) begin
      llamadaPiso = (len == restart_at) ? 4'(1 << f) : 4'b0000;
      step(1);
      len++;
    end
    llamadaPiso = '0;
    check("door_len", len, exp_len);
    if (restart_at >= 0) check("door_restart_nolatch", 32'(pendientes[f]), 0);
  endtask

  initial begin
    reset       = 1'b1;
    llamadaPiso = '0;
    sensorPiso  = 4'b0001;
    step(3);
    check("rst_estado", estado, 0);
    check("rst_motors", {motorSubir, motorBajar, puertaAbrir}, 0);
    check("rst_pend", pendientes, 0);
    check("rst_piso", pisoActual, 0);
    reset = 1'b0;
    step(2);

    // Single call from ground to floor 2.
    exp_q.push_back(2);
    pulse_call(4'b0100);
    check("t1_latch", pendientes, 4'b0100);
    check("t1_motor_early", motorSubir, 0);
    step(1);
    check("t1_motor_on", motorSubir, 1);
    check("t1_estado", estado, 1);
    wait_door(-1, 450);
    check("t1_pend_after", pendientes, 0);

    // Move to floor 1, then SCAN: up to 3 before serving 0.
    exp_q.push_back(1);
    pulse_call(4'b0010);
    wait_door(-1, 450);
    exp_q.push_back(3);
    pulse_call(4'b1000);
    step(1);
    check("t2_up", motorSubir, 1);
    exp_q.push_back(0);
    pulse_call(4'b0001);
    check("t2_pend", pendientes, 4'b1001);
    check("t2_keep_dir", estado, 1);
    wait_door(-1, 450);
    wait_door(-1, 450);

    // Idle at floor 2 triggers the return call after 9000 clocks.
    exp_q.push_back(2);
    pulse_call(4'b0100);
    wait_door(-1, 450);
    step(8999);
    check("t3_idle_pend", pendientes, 0);
    step(1);
    check("t3_auto_call", pendientes, 4'b0001);
    check("t3_not_yet", motorBajar, 0);
    step(1);
    check("t3_down", motorBajar, 1);
    exp_q.push_back(0);
    wait_door(-1, 450);

    // Same, with a call landing on the trigger cycle; direction is still up.
    exp_q.push_back(2);
    pulse_call(4'b0100);
    wait_door(-1, 450);
    step(8999);
    exp_q.push_back(3);
    exp_q.push_back(0);
    pulse_call(4'b1000);
    check("t3b_both", pendientes, 4'b1001);
    step(1);
    check("t3b_up", motorSubir, 1);
    wait_door(-1, 450);
    wait_door(-1, 450);

    // Door dwell restart by a call at the open floor.
    exp_q.push_back(2);
    pulse_call(4'b0100);
    wait_door(300, 751);
    check("t4_pend", pendientes, 0);

    // Reset in the middle of travel.
    pulse_call(4'b1000);
    step(1);
    check("t5_up", motorSubir, 1);
    step(3);
    reset = 1'b1;
    step(1);
    check("t5_motor", motorSubir, 0);
    check("t5_pend", pendientes, 0);
    check("t5_estado", estado, 0);
    reset = 1'b0;
    step(2);

`ifdef MONTACARGAS_WATCHDOG_EN
    begin
      int n;
      plant_en   = 1'b0;
      sensorPiso = '0;
      step(2);
      pulse_call(4'b0100);
      step(1);
      check("wd_moving", estado, 1);
      n = 0;
      while (estado != 3'd4 && n < 2000) begin
        step(1);
        n++;
      end
      check("wd_falla", estado, 4);
      check("wd_motors", {motorSubir, motorBajar, puertaAbrir}, 0);
      pulse_call(4'b0010);
      step(2);
      check("wd_frozen", pendientes, 4'b0100);
      check("wd_stay", estado, 4);
    end
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/montacargas_control.md
Name: montacargas_control

Overview:
- Top-level freight-elevator sequencer, clocked from the 150 Hz internal tick domain.
- Latches floor calls and schedules them SCAN-style: keep the current direction while calls remain ahead.
- Drives the motor up/down and door-open outputs, and times the door dwell.
- Owns the 1-minute idle supervision: after IDLE_TICKS idle clocks away from floor 1, it issues an automatic return call to floor 1 (index 0).

Parameters:
- N_PISOS, 4, number of floors; index 0 is floor 1 (ground).
- IDLE_TICKS, 9000, idle clocks before auto-return (60 s at 150 Hz).
- PUERTA_TICKS, 450, door-open dwell in clocks (3 s).
- VIAJE_TICKS, 1500, travel watchdog limit in clocks (10 s); used only with the optional feature.

Ports:
- clockInt_150Hz  in  1  system clock, 150 Hz.
- reset  in  1  synchronous, active-high.
- llamadaPiso  in  N_PISOS  call buttons, level; any cycle high latches the call.
- sensorPiso  in  N_PISOS  one-hot floor-level sensors; all-zero between floors.
- motorSubir  out  1  motor up command.
- motorBajar  out  1  motor down command.
- puertaAbrir  out  1  door open command.
- pisoActual  out  $clog2(N_PISOS)  last floor sensed.
- pendientes  out  N_PISOS  latched, unserved calls.
- estado  out  3  state code: REPOSO=0, SUBIENDO=1, BAJANDO=2, PUERTA=3, FALLA=4.

Behaviour:
- Only one clock; reset is synchronous and active-high.
- Reset (including mid-travel): all outputs 0, state REPOSO, pendientes cleared, dirección=up, all counters 0. Motor outputs drop at the same edge.
- pisoActual:
  - Loads the encoded index of sensorPiso whenever sensorPiso is nonzero.
  - Holds its value when sensorPiso is all-zero.
  - If sensorPiso is not one-hot, pisoActual holds and the cycle is ignored.
- Call latch: pendientes[k] <= pendientes[k] | llamadaPiso[k]. A call is cleared only when served.
- "Above" = any pendientes bit with index > pisoActual; "below" = any bit with index < pisoActual.
- REPOSO:
  - Call at pisoActual with sensorPiso[pisoActual]=1 → PUERTA; clear that bit.
  - Else if above and below both set → continue in the stored dirección.
  - Else if above only → SUBIENDO.
  - Else if below only → BAJANDO.
  - Idle counter increments each cycle while pendientes==0 and pisoActual!=0.
  - Idle counter resets to 0 on any nonzero pendientes, on any other state, or when pisoActual==0.
  - At count IDLE_TICKS-1: set pendientes[0]; counter returns to 0.
- SUBIENDO (motorSubir=1, dirección=up):
  - On a cycle with sensorPiso[k]=1 and pendientes[k]=1 → PUERTA; clear pendientes[k]; motorSubir=0 from the next edge.
  - Top floor reached with nothing pending there → REPOSO.
- BAJANDO: mirror of SUBIENDO with motorBajar, dirección=down.
- motorSubir and motorBajar are never both 1.
- PUERTA:
  - puertaAbrir=1; dwell counter counts 0..PUERTA_TICKS-1, then → REPOSO with puertaAbrir=0.
  - A new call at the current floor during PUERTA restarts the dwell counter and is not latched.
  - Calls for other floors latch normally.
- REPOSO after PUERTA re-evaluates the same cycle rules, so at most one idle cycle separates door close and motor start.
- Simultaneous events: a call arriving in the same cycle as the auto-return trigger takes precedence; the counter resets and pendientes[0] is still set.
- pendientes at width N_PISOS; index wrap-around is impossible. Out-of-range sensor bits are not present.

Optional Feature:
- Macro: MONTACARGAS_WATCHDOG_EN.
- Defined:
  - A travel counter runs in SUBIENDO/BAJANDO and resets on every change of pisoActual.
  - When it reaches VIAJE_TICKS-1 → FALLA: motors 0, puertaAbrir 0, estado=4, pendientes frozen.
  - Only reset exits FALLA.
- Not defined: no travel counter, FALLA unreachable, estado never 4. All other behaviour is identical.

Test Plan:
- Reset, then sensorPiso=0001, llamadaPiso=0100 for 1 cycle → motorSubir=1 next cycle. When sensorPiso=0100: motorSubir=0, puertaAbrir=1 for exactly 450 cycles, pendientes=0000, pisoActual=2.
- Car at floor 1 (index 1) moving up with calls 1000 and 0001 pending → serves 3 first, then BAJANDO to 0. Order of puertaAbrir pulses: floor 3, floor 0.
- Car idle at floor 2, no calls → pendientes[0] set at cycle 9000 of idle, motorBajar=1 next cycle. Same test with a call injected at cycle 8999 → call also latched, dirección rules apply.
- Door open at floor 2, llamadaPiso[2] pulsed at dwell 300 → puertaAbrir stays high for 450 more cycles; pendientes[2] stays 0.
- Reset asserted mid-SUBIENDO → motorSubir=0 and pendientes=0 at the next edge; estado=0.
- With MONTACARGAS_WATCHDOG_EN: SUBIENDO with sensorPiso held 0 for 1500 cycles → estado=4, motors 0; llamadaPiso is ignored until reset.
